ab_sym_framer: RTL and testbench
================================

AB_SYM_FRAMER -- requirements
Module: ab_sym_framer

Interface
REQ-001 Parameter: SYNC_PATTERN, default 8'hA5, frame sync word, compared MSB-first.
REQ-002 Parameter: PAYLOAD_SYMS, default 4, number of 2-bit symbols per frame (range 1..255).
REQ-003 Parameter: FIFO_DEPTH, default 4, symbol buffer entries (power of 2, at least 2).
REQ-004 clkAB  input  1  sole clock; all state updates on posedge clkAB.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  1  serial data bit.
REQ-007 din_vld  input  1  din is qualified this cycle.
REQ-008 sym_out  output  2  head-of-FIFO symbol; feeds the downstream 2-bit clkAB capture register.
REQ-009 sym_vld  output  1  sym_out holds a valid symbol (FIFO not empty).
REQ-010 sym_rdy  input  1  downstream accepts sym_out this cycle.
REQ-011 in_frame  output  1  FSM is in PAYLOAD state.
REQ-012 frame_err  output  1  one-cycle pulse on overflow abort.
REQ-013 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 FSM states: HUNT and PAYLOAD only; all outputs registered.
REQ-015 HUNT: on din_vld, 8-bit shift register updates as sr <= {sr[6:0], din}; no update without din_vld.
REQ-016 HUNT: when the updated sr value equals SYNC_PATTERN, the FSM enters PAYLOAD on the next edge; in_frame rises 1 cycle after the last sync bit's din_vld cycle.
REQ-017 Entering PAYLOAD clears sr, pair-bit flag and symbol counter; the first din_vld bit in PAYLOAD is the first payload bit.
REQ-018 PAYLOAD: bits pair up; the first accepted bit is sym[1], the second is sym[0]; a symbol is pushed to the FIFO in the cycle its second bit is accepted.
REQ-019 PAYLOAD: after the PAYLOAD_SYMS-th push, the FSM returns to HUNT on the next edge, with sr = 0; sync detection never overlaps payload bits.
REQ-020 Gaps in din_vld are allowed anywhere; state, pair flag and counters hold.
REQ-021 FIFO: sym_vld = (fifo_cnt != 0); pop occurs when sym_vld && sym_rdy; sym_out advances to the next entry on the following cycle.
REQ-022 Latency: a symbol pushed into an empty FIFO appears on sym_out with sym_vld=1 one cycle after its second bit is accepted.
REQ-023 Push into a full FIFO with a simultaneous pop is accepted; fifo_cnt is unchanged.
REQ-024 Push into a full FIFO without a pop is an overflow: the symbol is dropped, frame_err pulses for 1 cycle, and the FSM returns to HUNT with sr = 0; symbols already in the FIFO are kept.
REQ-025 Pop on an empty FIFO is ignored; sym_rdy with sym_vld=0 has no effect.
REQ-026 Pointers wrap modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH.
REQ-027 sym_out is 2'b00 when the FIFO is empty.

Reset
REQ-028 rst takes priority over all other inputs at any point, including mid-frame and mid-pair.
REQ-029 On reset: state = HUNT, sr = 0, pair flag = 0, symbol counter = 0, FIFO pointers = 0, fifo_cnt = 0, sym_vld = 0, sym_out = 2'b00, in_frame = 0, frame_err = 0.
REQ-030 A partially received frame or symbol is discarded on reset; no push occurs in the reset cycle.

Verification
REQ-031 Sync then payload: serial 10100101 followed by 10 01 11 00, sym_rdy=1 -> in_frame rises 1 cycle after the last sync bit; sym_out = 2,1,3,0 in order; in_frame falls after the 4th symbol.
REQ-032 Near-miss sync: 10100100 then 1 -> no in_frame; sync match on the next seven bits completing A5 -> in_frame=1.
REQ-033 Overflow: FIFO_DEPTH=4, PAYLOAD_SYMS=6, sym_rdy=0 -> fifo_cnt reaches 4; 5th symbol -> frame_err pulse, in_frame=0, fifo_cnt stays 4; contents are symbols 1-4.
REQ-034 Full with simultaneous pop: fifo_cnt=4 and push in the same cycle as sym_rdy=1 -> no frame_err, fifo_cnt stays 4, order preserved.
REQ-035 Reset mid-frame after 1 bit of symbol 2 -> all outputs at reset values next cycle; a fresh A5 plus payload frame decodes correctly.
REQ-036 din_vld gaps of 1-3 cycles between every bit -> identical symbol sequence to REQ-031.

Source files
------------

// File: rtl/ab_sym_framer.sv
// ab_sym_framer
//   Hunts a serial bit stream for an 8-bit sync word, then packs the next
//   PAYLOAD_SYMS bit pairs into 2-bit symbols and buffers them in a small
//   FIFO for a downstream consumer. An overflowing push drops the symbol,
//   pulses frame_err and aborts the frame back to sync hunting.
//
// Ports
//   clkAB     in   sole clock, rising edge
//   rst       in   synchronous, active-high reset
//   din       in   serial data bit
//   din_vld   in   din qualifier
//   sym_out   out  [1:0] head-of-FIFO symbol (2'b00 when empty)
//   sym_vld   out  FIFO not empty
//   sym_rdy   in   downstream accepts sym_out this cycle
//   in_frame  out  FSM is in PAYLOAD
//   frame_err out  one-cycle pulse on overflow abort
//   fifo_cnt  out  FIFO occupancy, 0..FIFO_DEPTH
module ab_sym_framer #(
  parameter logic [7:0]  SYNC_PATTERN = 8'hA5,
  parameter int unsigned PAYLOAD_SYMS = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clkAB,
  input  logic                          rst,
  input  logic                          din,
  input  logic                          din_vld,
  output logic [1:0]                    sym_out,
  output logic                          sym_vld,
  input  logic                          sym_rdy,
  output logic                          in_frame,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LAST_SYM = 8'(PAYLOAD_SYMS - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t        state;
  // Only the last 7 bits are kept: the match is taken on {sr, din}, i.e.
  // the value the 8-bit shift register would hold after this bit.
  logic [6:0]    sr;
  logic          pair;
  logic          sym_hi;
  logic [7:0]    sym_cnt;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          pop;
  logic          full;
  logic          push_req;
  logic          push;
  logic          overflow;
  logic          sync_hit;
  logic [1:0]    new_sym;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    head_nxt;

  always_comb begin
    pop        = sym_vld && sym_rdy;
    full       = (fifo_cnt == FULL_CNT);
    push_req   = (state == PAYLOAD) && din_vld && pair;
    push       = push_req && (!full || pop);
    overflow   = push_req && full && !pop;
    new_sym    = {sym_hi, din};
    sync_hit   = ({sr, din} == SYNC_PATTERN);
    rd_ptr_inc = rd_ptr + AW'(1);

    cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      cnt_nxt = fifo_cnt + CW'(1);
    end else if (pop && !push) begin
      cnt_nxt = fifo_cnt - CW'(1);
    end

    // Registered head: the incoming symbol bypasses into sym_out whenever
    // it becomes the head (empty FIFO, or popping the last stored entry).
    head_nxt = sym_out;
    if (cnt_nxt == '0) begin
      head_nxt = '0;
    end else if (fifo_cnt == '0) begin
      head_nxt = new_sym;
    end else if (pop) begin
      head_nxt = (fifo_cnt == CW'(1)) ? new_sym : mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clkAB) begin
    if (!rst && push) begin
      mem[wr_ptr] <= new_sym;
    end
  end

  always_ff @(posedge clkAB) begin
    if (rst) begin
      state     <= HUNT;
      sr        <= '0;
      pair      <= 1'b0;
      sym_hi    <= 1'b0;
      sym_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      sym_vld   <= 1'b0;
      sym_out   <= '0;
      in_frame  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      fifo_cnt  <= cnt_nxt;
      sym_vld   <= (cnt_nxt != '0);
      sym_out   <= head_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end

      case (state)
        HUNT: begin
          if (din_vld) begin
            if (sync_hit) begin
              state    <= PAYLOAD;
              in_frame <= 1'b1;
              sr       <= '0;
              pair     <= 1'b0;
              sym_cnt  <= '0;
            end else begin
              sr <= {sr[5:0], din};
            end
          end
        end
        PAYLOAD: begin
          if (din_vld) begin
            if (!pair) begin
              sym_hi <= din;
              pair   <= 1'b1;
            end else begin
              pair <= 1'b0;
              if (overflow) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                in_frame  <= 1'b0;
                sr        <= '0;
              end else if (sym_cnt == LAST_SYM) begin
                state    <= HUNT;
                in_frame <= 1'b0;
                sr       <= '0;
              end else begin
                sym_cnt <= sym_cnt + 8'd1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_ab_sym_framer.sv
// tb_ab_sym_framer
//   Directed bench for ab_sym_framer. Instance a uses default parameters,
//   instance b uses PAYLOAD_SYMS=6 for the overflow / full-with-pop cases.
//   Both share the same stimulus; each step only checks the instance it targets.
module tb_ab_sym_framer;

  logic       clkAB = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       sym_rdy = 1'b0;

  logic [1:0] a_sym_out, b_sym_out;
  logic       a_sym_vld, b_sym_vld;
  logic       a_in_frame, b_in_frame;
  logic       a_frame_err, b_frame_err;
  logic [2:0] a_fifo_cnt, b_fifo_cnt;

  int checks = 0;
  int failures = 0;
  int nbits = 0;

  always #5 clkAB = ~clkAB;

  ab_sym_framer dut_a (
    .clkAB(clkAB), .rst(rst), .din(din), .din_vld(din_vld),
    .sym_out(a_sym_out), .sym_vld(a_sym_vld), .sym_rdy(sym_rdy),
    .in_frame(a_in_frame), .frame_err(a_frame_err), .fifo_cnt(a_fifo_cnt)
  );

  ab_sym_framer #(.SYNC_PATTERN(8'hA5), .PAYLOAD_SYMS(6), .FIFO_DEPTH(4)) dut_b (
    .clkAB(clkAB), .rst(rst), .din(din), .din_vld(din_vld),
    .sym_out(b_sym_out), .sym_vld(b_sym_vld), .sym_rdy(sym_rdy),
    .in_frame(b_in_frame), .frame_err(b_frame_err), .fifo_cnt(b_fifo_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clkAB);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gapped);
    int gap;
    gap = gapped ? 1 + (nbits % 3) : 0;
    nbits++;
    for (int i = 0; i < gap; i++) begin
      din_vld = 1'b0;
      step();
    end
    din = b;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
  endtask

  task automatic send_sync(input bit gapped);
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(w[i], gapped);
  endtask

  task automatic send_sym(input logic [1:0] s, input bit gapped);
    send_bit(s[1], gapped);
    send_bit(s[0], gapped);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_a_sym_out"}, 32'(a_sym_out), 0);
    chk({tag, "_a_sym_vld"}, 32'(a_sym_vld), 0);
    chk({tag, "_a_in_frame"}, 32'(a_in_frame), 0);
    chk({tag, "_a_frame_err"}, 32'(a_frame_err), 0);
    chk({tag, "_a_fifo_cnt"}, 32'(a_fifo_cnt), 0);
  endtask

  // A5 then symbols 2,1,3,0 on instance a with sym_rdy=1.
  task automatic frame_a(input string tag, input bit gapped);
    logic [7:0] w;
    logic [1:0] syms [4];
    w = 8'hA5;
    syms[0] = 2'd2; syms[1] = 2'd1; syms[2] = 2'd3; syms[3] = 2'd0;
    for (int i = 7; i >= 1; i--) send_bit(w[i], gapped);
    chk({tag, "_inframe_pre"}, 32'(a_in_frame), 0);
    send_bit(w[0], gapped);
    chk({tag, "_inframe_rise"}, 32'(a_in_frame), 1);
    for (int k = 0; k < 4; k++) begin
      send_bit(syms[k][1], gapped);
      chk({tag, "_vld_midpair"}, 32'(a_sym_vld), 0);
      send_bit(syms[k][0], gapped);
      chk({tag, "_sym_vld"}, 32'(a_sym_vld), 1);
      chk({tag, "_sym_out"}, 32'(a_sym_out), 32'(syms[k]));
      chk({tag, "_cnt"}, 32'(a_fifo_cnt), 1);
      chk({tag, "_inframe"}, 32'(a_in_frame), (k == 3) ? 0 : 1);
    end
    step();
    chk({tag, "_drained"}, 32'(a_sym_vld), 0);
  endtask

  initial begin
    logic [8:0] near;
    logic [6:0] rest;
    logic [1:0] exp_q [4];

    // Reset values
    rst = 1'b1;
    step();
    chk_reset_a("rst0");
    chk("rst0_b_cnt", 32'(b_fifo_cnt), 0);
    chk("rst0_b_vld", 32'(b_sym_vld), 0);
    rst = 1'b0;

    // Sync then payload, back-to-back bits
    sym_rdy = 1'b1;
    frame_a("basic", 1'b0);

    // Near-miss sync followed by a real match
    near = 9'b101001001;
    for (int i = 8; i >= 0; i--) send_bit(near[i], 1'b0);
    chk("near_miss", 32'(a_in_frame), 0);
    rest = 7'b0100101;
    for (int i = 6; i >= 1; i--) send_bit(rest[i], 1'b0);
    chk("near_pre", 32'(a_in_frame), 0);
    send_bit(rest[0], 1'b0);
    chk("near_hit", 32'(a_in_frame), 1);

    // Overflow on instance b (6-symbol frame, depth 4)
    rst = 1'b1; step(); rst = 1'b0;
    sym_rdy = 1'b0;
    send_sync(1'b0);
    chk("ovf_inframe", 32'(b_in_frame), 1);
    exp_q[0] = 2'd3; exp_q[1] = 2'd1; exp_q[2] = 2'd2; exp_q[3] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      send_sym(exp_q[k], 1'b0);
      chk("ovf_fill_cnt", 32'(b_fifo_cnt), 32'(k + 1));
      chk("ovf_head", 32'(b_sym_out), 32'(exp_q[0]));
    end
    chk("ovf_err_pre", 32'(b_frame_err), 0);
    send_sym(2'd1, 1'b0);
    chk("ovf_err", 32'(b_frame_err), 1);
    chk("ovf_inframe_drop", 32'(b_in_frame), 0);
    chk("ovf_cnt_hold", 32'(b_fifo_cnt), 4);
    step();
    chk("ovf_err_pulse", 32'(b_frame_err), 0);
    sym_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain", 32'(b_sym_out), 32'(exp_q[k]));
      step();
    end
    chk("ovf_empty_vld", 32'(b_sym_vld), 0);
    chk("ovf_empty_out", 32'(b_sym_out), 0);
    chk("ovf_empty_cnt", 32'(b_fifo_cnt), 0);
    step();
    chk("pop_empty_cnt", 32'(b_fifo_cnt), 0);

    // Full FIFO with simultaneous push and pop
    rst = 1'b1; step(); rst = 1'b0;
    sym_rdy = 1'b0;
    send_sync(1'b0);
    exp_q[0] = 2'd1; exp_q[1] = 2'd2; exp_q[2] = 2'd3; exp_q[3] = 2'd0;
    for (int k = 0; k < 4; k++) send_sym(exp_q[k], 1'b0);
    chk("fp_full", 32'(b_fifo_cnt), 4);
    send_bit(1'b1, 1'b0);
    din = 1'b0; din_vld = 1'b1; sym_rdy = 1'b1;
    step();
    din_vld = 1'b0;
    chk("fp_no_err", 32'(b_frame_err), 0);
    chk("fp_cnt", 32'(b_fifo_cnt), 4);
    chk("fp_inframe", 32'(b_in_frame), 1);
    exp_q[0] = 2'd2; exp_q[1] = 2'd3; exp_q[2] = 2'd0; exp_q[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      chk("fp_order", 32'(b_sym_out), 32'(exp_q[k]));
      step();
    end
    chk("fp_empty", 32'(b_sym_vld), 0);

    // Reset mid-frame, one bit into symbol 2, then a clean frame
    rst = 1'b1; step(); rst = 1'b0;
    sym_rdy = 1'b0;
    send_sync(1'b0);
    send_sym(2'd2, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("mid_cnt_pre", 32'(a_fifo_cnt), 1);
    rst = 1'b1; din = 1'b0; din_vld = 1'b1;
    step();
    rst = 1'b0; din_vld = 1'b0;
    chk_reset_a("midrst");
    sym_rdy = 1'b1;
    frame_a("after_rst", 1'b0);

    // Same frame with 1-3 idle cycles before every bit
    nbits = 0;
    frame_a("gapped", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
